// File: rtl/inst_prefetch.sv
// Instruction prefetch: sequential Avalon word reads from the boot ROM, buffered in a small FIFO.
// Latency: read accepted at cycle N -> data captured at N+1 -> o_Inst_Valid at N+2.
// Backpressure: a read issues only while fifo_count + inflight < FIFO_DEPTH; a stalled read is held.
//
// Ports:
//   i_Clk, i_Reset                  clock, synchronous active-high reset
//   o_AV_Address/o_AV_Read          Avalon read master request
//   i_AV_ReadData/i_AV_WaitRequest  ROM data (fixed 1-cycle latency) and slave stall
//   i_Redirect/i_RedirectPC         one-cycle flush and restart at a new PC
//   o_Inst_Valid/o_Inst/o_Inst_PC   instruction to decode, with i_Inst_Ready handshake
module inst_prefetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  output logic [31:0] o_AV_Address,
  output logic        o_AV_Read,
  input  logic [31:0] i_AV_ReadData,
  input  logic        i_AV_WaitRequest,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  output logic        o_Inst_Valid,
  output logic [31:0] o_Inst,
  output logic [31:0] o_Inst_PC,
  input  logic        i_Inst_Ready
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  // Fetch-side state
  logic [31:0] fetch_pc;     // address of the read being presented / next to issue
  logic [31:0] redir_pc;     // redirect target parked behind a stalled read
  logic [31:0] resp_pc;      // PC of the response due this cycle
  logic        started;      // holds off the first read until one cycle after reset
  logic        stalled;      // a read was presented and stalled last cycle
  logic        inflight;     // a response arrives this cycle
  logic        discard;      // that response belongs to a flushed stream
  logic        redir_pend;    // redirect arrived while a read was stalled

  // Instruction FIFO
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        empty;
  logic        credit;
  logic        accept;
  logic        push;
  logic        pop;
  logic        stall_now;
  logic [CW:0] used;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = i_RedirectPC & 32'hFFFF_FFFC;
  assign empty        = (count == '0);

  // Credit ignores same-cycle pops so the issue path never sees i_Inst_Ready.
  assign used   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign credit = (used < DEPTH_L);

  // Once presented, a read stays up until accepted regardless of credit or redirect.
  assign o_AV_Read    = started && (stalled || credit);
  assign o_AV_Address = fetch_pc;

  assign accept    = o_AV_Read && !i_AV_WaitRequest;
  assign stall_now = o_AV_Read && i_AV_WaitRequest;

  // Responses landing in a redirect cycle are dropped along with the flush.
  assign push = inflight && !discard && !i_Redirect;
  assign pop  = !empty && i_Inst_Ready && !i_Redirect;

  // Fetch control
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      started    <= 1'b0;
      stalled    <= 1'b0;
      inflight   <= 1'b0;
      discard    <= 1'b0;
      redir_pend <= 1'b0;
      fetch_pc   <= RESET_PC;
      redir_pc   <= RESET_PC;
      resp_pc    <= '0;
    end else begin
      started  <= 1'b1;
      stalled  <= stall_now;
      inflight <= accept;
      if (accept) begin
        resp_pc <= fetch_pc;
        // A read accepted in a redirect cycle, or one held across a redirect, is stale.
        discard <= i_Redirect || redir_pend;
      end
      if (i_Redirect && stall_now) begin
        // Cannot move the address under a stalled read: park the target (last one wins).
        redir_pend <= 1'b1;
        redir_pc   <= redirect_tgt;
      end else if (i_Redirect) begin
        redir_pend <= 1'b0;
        fetch_pc   <= redirect_tgt;
      end else if (accept) begin
        redir_pend <= 1'b0;
        fetch_pc   <= redir_pend ? redir_pc : fetch_pc + 32'd4;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while empty.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= i_AV_ReadData;
      mem_pc[wr_ptr]   <= resp_pc;
    end
  end

  assign o_Inst_Valid = !empty;
  assign o_Inst       = empty ? '0 : mem_inst[rd_ptr];
  assign o_Inst_PC    = empty ? '0 : mem_pc[rd_ptr];

endmodule

// File: tb/tb_inst_prefetch.sv
`timescale 1ns/1ps
module tb_inst_prefetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] av_addr;
  logic        av_read;
  logic [31:0] av_rdata;
  logic        av_wait;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ready;

  always #5 clk = ~clk;

  inst_prefetch #(.FIFO_DEPTH(4), .RESET_PC(RST_PC)) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .o_AV_Address(av_addr),
    .o_AV_Read(av_read),
    .i_AV_ReadData(av_rdata),
    .i_AV_WaitRequest(av_wait),
    .i_Redirect(redirect),
    .i_RedirectPC(redirect_pc),
    .o_Inst_Valid(inst_valid),
    .o_Inst(inst),
    .o_Inst_PC(inst_pc),
    .i_Inst_Ready(ready)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [31:0] exp_addr;
  logic [31:0] redir_tgt;
  bit   redir_pend;
  int   acc_cnt = 0;
  int   pop_cnt = 0;
  bit   ovf_seen = 1'b0;
  logic        mon_acc;
  logic [31:0] mon_addr;
  exp_t        mon_e;

  // ROM model plus scoreboard. Samples on the falling edge, drives read data after the rising edge.
  initial begin
    av_rdata   = 32'hDEAD_BEEF;
    exp_addr   = RST_PC;
    redir_tgt  = '0;
    redir_pend = 1'b0;
    forever begin
      @(negedge clk);
      mon_acc  = av_read && !av_wait;
      mon_addr = av_addr;
      if (dut.count > 3'd4) ovf_seen = 1'b1;
      if (rst) begin
        exp_q.delete();
        exp_addr   = RST_PC;
        redir_pend = 1'b0;
        mon_acc    = 1'b0;
      end else begin
        if (mon_acc) begin
          acc_cnt++;
          checks++;
          if (av_addr !== exp_addr) begin
            errors++;
            $display("FAIL rd_addr: got %h expected %h", av_addr, exp_addr);
          end
          if (!redirect && !redir_pend)
            exp_q.push_back({32'hA000_0000 + (exp_addr >> 2), exp_addr});
        end
        if (inst_valid && ready && !redirect) begin
          pop_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got inst %h pc %h expected no output", inst, inst_pc);
          end else begin
            mon_e = exp_q.pop_front();
            if ({inst, inst_pc} !== mon_e) begin
              errors++;
              $display("FAIL pop_data: got %h/%h expected %h/%h", inst, inst_pc, mon_e.word, mon_e.pc);
            end
          end
        end
        if (redirect) begin
          exp_q.delete();
          redir_tgt = redirect_pc & 32'hFFFF_FFFC;
          if (av_read && av_wait) redir_pend = 1'b1;
          else begin
            exp_addr   = redir_tgt;
            redir_pend = 1'b0;
          end
        end else if (mon_acc) begin
          if (redir_pend) begin
            exp_addr   = redir_tgt;
            redir_pend = 1'b0;
          end else begin
            exp_addr = exp_addr + 32'd4;
          end
        end
      end
      @(posedge clk);
      #1;
      av_rdata = mon_acc ? 32'hA000_0000 + (mon_addr >> 2) : 32'hDEAD_BEEF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; av_wait = 1'b0; ready = rdy;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (av_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b expected 0", av_read); end
    checks++; if (av_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", av_addr, RST_PC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", inst_pc); end
  endtask

  task automatic test_stream();
    bit found = 1'b0;
    int p0;
    do_reset(1'b1);
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (av_read) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stream_first_read: got no read expected one within 10 cycles"); end
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_n1: got %b expected 0", inst_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid_n2: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'hA000_0000) begin errors++; $display("FAIL stream_first_inst: got %h expected a0000000", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL stream_first_pc: got %h expected 0", inst_pc); end
    p0 = pop_cnt;
    repeat (20) tick();
    checks++;
    if (pop_cnt - p0 != 20) begin errors++; $display("FAIL stream_rate: got %0d pops expected 20", pop_cnt - p0); end
  endtask

  task automatic test_backpressure();
    int a0;
    int p0;
    do_reset(1'b0);
    a0 = acc_cnt;
    repeat (20) tick();
    checks++; if (acc_cnt - a0 != 4) begin errors++; $display("FAIL bp_reads: got %0d expected 4", acc_cnt - a0); end
    checks++; if (av_read !== 1'b0) begin errors++; $display("FAIL bp_read_low: got %b expected 0", av_read); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'hA000_0000) begin errors++; $display("FAIL bp_inst: got %h expected a0000000", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_pc: got %h expected 0", inst_pc); end
    ready = 1'b1;
    p0 = pop_cnt;
    repeat (10) tick();
    checks++; if (pop_cnt - p0 != 10) begin errors++; $display("FAIL bp_drain: got %0d pops expected 10", pop_cnt - p0); end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    int p0;
    do_reset(1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (av_read && av_addr == 32'h8) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_find: got no read to 8 expected one within 20 cycles"); end
    av_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (av_addr !== 32'h8) begin errors++; $display("FAIL stall_addr_%0d: got %h expected 8", i, av_addr); end
      checks++; if (av_read !== 1'b1) begin errors++; $display("FAIL stall_read_%0d: got %b expected 1", i, av_read); end
      tick();
    end
    av_wait = 1'b0;
    p0 = pop_cnt;
    repeat (20) tick();
    checks++; if (pop_cnt - p0 < 15) begin errors++; $display("FAIL stall_resume: got %0d pops expected at least 15", pop_cnt - p0); end
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] pc, input logic [31:0] word);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (inst_valid) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || inst_pc !== pc || inst !== word) begin
      errors++;
      $display("FAIL %s: got valid %b %h/%h expected %h/%h", name, found, inst, inst_pc, word, pc);
    end
  endtask

  task automatic test_redirect_inflight();
    bit found = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (av_read && av_addr == 32'h10) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL redir_find: got no read to 10 expected one within 20 cycles"); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0; redirect_pc = '0;
    checks++; if (av_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h expected 40", av_addr); end
    checks++; if (av_read !== 1'b1) begin errors++; $display("FAIL redir_read: got %b expected 1", av_read); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", inst_valid); end
    wait_first_valid("redir_next_out", 32'h40, 32'hA000_0010);
    repeat (5) tick();
  endtask

  task automatic test_redirect_stall();
    bit found = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (av_read && av_addr == 32'h14) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstall_find: got no read to 14 expected one within 20 cycles"); end
    av_wait = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) av_wait = 1'b0;
      checks++;
      if (av_addr !== 32'h14 || av_read !== 1'b1) begin
        errors++;
        $display("FAIL rstall_hold_%0d: got %h/%b expected 14/1", i, av_addr, av_read);
      end
      tick();
      redirect = 1'b0; redirect_pc = '0;
    end
    checks++;
    if (av_addr !== 32'h40 || av_read !== 1'b1) begin
      errors++;
      $display("FAIL rstall_target: got %h/%b expected 40/1", av_addr, av_read);
    end
    wait_first_valid("rstall_next_out", 32'h40, 32'hA000_0010);
    repeat (5) tick();
  endtask

  task automatic test_reset_midstream();
    int a0;
    bit found = 1'b0;
    do_reset(1'b0);
    a0 = acc_cnt;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (acc_cnt - a0 == 4) found = 1'b1;
    end
    checks++;
    if (!found || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill: got found %b valid %b expected 1/1", found, inst_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", inst_valid); end
    checks++; if (av_read !== 1'b0) begin errors++; $display("FAIL mid_read: got %b expected 0", av_read); end
    ready = 1'b1;
    wait_first_valid("mid_refetch", RST_PC, 32'hA000_0000);
    repeat (5) tick();
  endtask

  initial begin
    rst = 1'b1; av_wait = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect_inflight();
    test_redirect_stall();
    test_reset_midstream();
    checks++;
    if (ovf_seen) begin errors++; $display("FAIL fifo_overflow: got count above 4 expected at most 4"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_prefetch.md
Name: inst_prefetch

Overview:
- Instruction prefetch stage sitting directly upstream of the boot ROM's instruction read port.
- Acts as an Avalon read master that issues sequential word fetches.
- Absorbs the ROM's fixed 1-cycle read latency and buffers fetched words in a small FIFO.
- Presents instructions to the CPU decode stage through a valid/ready handshake, and supports PC redirect (branch/jump/trap) with flush.

Parameters:
- FIFO_DEPTH, 4, number of instruction entries buffered; power of two, >= 2.
- RESET_PC, 32'h00000000, byte address of the first fetch after reset; bits [1:0] must be 0.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- o_AV_Address  out  32  byte address of the current read; bits [1:0] always 0.
- o_AV_Read  out  1  read request.
- i_AV_ReadData  in  32  read data, valid exactly 1 cycle after an accepted read.
- i_AV_WaitRequest  in  1  slave stall; the read is accepted when o_AV_Read && !i_AV_WaitRequest.
- i_Redirect  in  1  single-cycle pulse: flush and restart fetch at i_RedirectPC.
- i_RedirectPC  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- o_Inst_Valid  out  1  o_Inst/o_Inst_PC hold a valid instruction.
- o_Inst  out  32  instruction word.
- o_Inst_PC  out  32  byte address of o_Inst.
- i_Inst_Ready  in  1  consumer accepts the instruction when o_Inst_Valid && i_Inst_Ready.

Behaviour:
- Reset (synchronous, active-high), takes effect at the next posedge i_Clk:
  - o_AV_Read=0, o_AV_Address=RESET_PC.
  - o_Inst_Valid=0, o_Inst=0, o_Inst_PC=0.
  - FIFO empty; in-flight flag=0; discard flag=0; fetch PC=RESET_PC.
  - Reset asserted mid-operation abandons any in-flight response.
- Credit:
  - A read may be issued only when fifo_count + inflight < FIFO_DEPTH, where inflight is 0 or 1 (the response due next cycle).
  - Pops in the same cycle do not count as free space; this keeps the issue logic off the consumer path.
- Issue:
  - The first read is asserted the cycle after reset deasserts.
  - On acceptance, the accepted address is recorded as the response's PC, the fetch PC advances by 4 (wraps modulo 2^32), and inflight is set for the next cycle.
  - Back-to-back issue is allowed: with no stall, one word per cycle is sustained.
- Stall:
  - While o_AV_Read=1 and i_AV_WaitRequest=1, o_AV_Address and o_AV_Read must stay constant.
  - o_AV_Read is never deasserted before acceptance, even when a redirect arrives.
- Response:
  - The cycle after acceptance, i_AV_ReadData and its PC are pushed into the FIFO, unless the discard flag for that response is set.
  - Overflow is impossible by construction; the bench asserts this.
- Output:
  - FIFO head drives o_Inst/o_Inst_PC, with o_Inst_Valid = !empty (first-word fall-through from a registered FIFO).
  - Push-to-output latency is 1 cycle: an accepted read at cycle N gives data at N+1 and o_Inst_Valid at N+2.
  - Pop on o_Inst_Valid && i_Inst_Ready.
  - Simultaneous push and pop keeps the count unchanged.
- Redirect, with i_Redirect=1 at cycle N:
  - FIFO is flushed at N+1, so o_Inst_Valid=0 at N+1; any pop at N is ignored.
  - Fetch PC is set to {i_RedirectPC[31:2],2'b00}.
  - Any response arriving at N+1 (read accepted at N) is discarded.
  - If a read is stalled at N, it is held until accepted; its response is discarded. The target read is issued in the cycle after that acceptance.
  - If no read is stalled, the target read is issued at N+1.
  - A second redirect before the target issues overrides the target (last wins).
  - Redirect and reset together: reset wins.
- The consumer may hold i_Inst_Ready=0 indefinitely; fetching stops when credits are exhausted and resumes one cycle after the first pop frees a credit.

Test Plan:
- Reset, then stream with the ROM model returning word k = 32'hA000_0000+k, i_Inst_Ready=1, no stalls -> o_AV_Address 0,4,8,...; o_Inst_Valid first high 2 cycles after the first accept; o_Inst/o_Inst_PC = A0000000/0, A0000001/4, ... with one per cycle.
- i_Inst_Ready=0 for 20 cycles -> exactly 4 reads accepted (addresses 0..C), o_AV_Read low afterwards, o_Inst stable at A0000000/PC 0; after Ready=1 the words appear in order with none lost or duplicated.
- i_AV_WaitRequest=1 for 3 cycles on the read to 8 -> o_AV_Address holds 8 and o_AV_Read holds 1 for all 3 cycles; the output sequence is unchanged apart from the delay.
- Redirect to 32'h0000_0043 while the read to 10 is in flight -> the word from 10 never appears; the next read address is 40; the next output is o_Inst_PC=40.
- Redirect during a stalled read to 14 (WaitRequest held 2 more cycles) -> 14 is held until accepted and its data is dropped, then the read to 40 issues the next cycle.
- Assert i_Reset mid-stream with 3 entries buffered -> the next cycle has o_Inst_Valid=0 and o_AV_Read=0; refetch restarts at RESET_PC with no stale word emitted.
